// File: rtl/filter_window_ctrl_pkg.sv
// Shared types and default geometry for the 3x3 filter window controller.
package filter_pkg;

  localparam int IMG_W_DEF    = 640;
  localparam int IMG_H_DEF    = 480;
  localparam int FILT_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/filter_window_ctrl_if.sv
// Pixel handshake, window control and output-tag bundle for filter_window_ctrl.
interface filter_window_ctrl_if
  import filter_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          win_shift;
  logic          flushing;
  logic          out_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          border;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid,
    input  in_ready, win_shift, flushing, out_valid, out_row, out_col,
           border, busy, done
  );

  modport slave (
    input  start, in_valid,
    output in_ready, win_shift, flushing, out_valid, out_row, out_col,
           border, busy, done
  );

endinterface

// File: rtl/filter_window_ctrl_valid_delay_pipe.sv
// Fixed-depth shift register that tracks the filter datapath latency.
module valid_delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift one stage per cycle; reset empties every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/filter_window_ctrl.sv
// Sequencing controller for a 3x3 line-buffer filter: admits a frame of
// pixels, flushes the window with zero pixels, and tags each filtered output
// with its centre coordinate and an edge flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_FILL  | accepting pixels, window centre not yet valid
//   ST_RUN   | accepting pixels, every shift produces a centre
//   ST_FLUSH | IMG_W+1 zero-pixel shifts to push out the last line
//   ST_DRAIN | waiting for the last tagged pixel to leave the datapath
module filter_window_ctrl
  import filter_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int FILT_LAT = FILT_LAT_DEF
) (
  input logic               clk,
  input logic               rst,
  filter_window_ctrl_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);
  localparam int PW = 1 + RW + CW;

  state_e        state_q, state_d;
  logic          done_q, done_d;
  logic [CW-1:0] in_col_q, ctr_col_q, ev_col_q, out_c;
  logic [RW-1:0] in_row_q, ctr_row_q, ev_row_q, out_r;
  logic          ev_v_q, centre_fin_q, out_v;
  logic [FW-1:0] flush_cnt_q;
  logic [PW-1:0] pipe_out;
  logic          accept, shift, frame_start, fill_last, in_last;
  logic          ctr_ev, ctr_last, out_last;

  assign bus.in_ready = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign accept       = bus.in_valid && bus.in_ready;
  assign shift        = accept || (state_q == ST_FLUSH);
  assign frame_start  = (state_q == ST_IDLE) && bus.start;

  // Pixel (1,0) is the (IMG_W+1)-th accepted pixel: first full window centre.
  assign fill_last = accept && (state_q == ST_FILL) &&
                     (in_row_q == RW'(1)) && (in_col_q == '0);
  assign in_last   = accept && (in_row_q == RW'(IMG_H - 1)) &&
                     (in_col_q == CW'(IMG_W - 1));
  assign ctr_ev    = shift && !centre_fin_q &&
                     ((state_q == ST_RUN) || (state_q == ST_FLUSH) || fill_last);
  assign ctr_last  = (ctr_row_q == RW'(IMG_H - 1)) && (ctr_col_q == CW'(IMG_W - 1));
  assign out_last  = out_v && (out_r == RW'(IMG_H - 1)) && (out_c == CW'(IMG_W - 1));

  // State register and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; done fires as DRAIN retires the last tagged pixel.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FILL;
      ST_FILL:  if (fill_last) state_d = ST_RUN;
      ST_RUN:   if (in_last) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_cnt_q == '0) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Input raster position, advanced only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      in_col_q <= '0;
      in_row_q <= '0;
    end else if (accept) begin
      if (in_col_q == CW'(IMG_W - 1)) begin
        in_col_q <= '0;
        in_row_q <= (in_row_q == RW'(IMG_H - 1)) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_q <= in_col_q + CW'(1);
      end
    end
  end

  // Flush down-counter: loaded with IMG_W, FLUSH ends on terminal count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_FLUSH)) begin
      flush_cnt_q <= FW'(IMG_W);
    end else if ((state_q == ST_FLUSH) && (flush_cnt_q != '0)) begin
      flush_cnt_q <= flush_cnt_q - FW'(1);
    end
  end

  // Centre counters; the window register captures the shifted pixel on the
  // edge, so the centre tag is presented one cycle after the shift.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      ctr_col_q    <= '0;
      ctr_row_q    <= '0;
      centre_fin_q <= 1'b0;
      ev_v_q       <= 1'b0;
      ev_row_q     <= '0;
      ev_col_q     <= '0;
    end else begin
      ev_v_q <= ctr_ev;
      if (ctr_ev) begin
        ev_row_q <= ctr_row_q;
        ev_col_q <= ctr_col_q;
        if (ctr_last) centre_fin_q <= 1'b1;
        if (ctr_col_q == CW'(IMG_W - 1)) begin
          ctr_col_q <= '0;
          ctr_row_q <= (ctr_row_q == RW'(IMG_H - 1)) ? '0 : ctr_row_q + RW'(1);
        end else begin
          ctr_col_q <= ctr_col_q + CW'(1);
        end
      end
    end
  end

  valid_delay_pipe #(
    .WIDTH (PW),
    .DEPTH (FILT_LAT)
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .d_i ({ev_v_q, ev_row_q, ev_col_q}),
    .q_o (pipe_out)
  );

  assign out_v = pipe_out[PW-1];
  assign out_r = pipe_out[CW +: RW];
  assign out_c = pipe_out[CW-1:0];

  assign bus.win_shift = shift;
  assign bus.flushing  = (state_q == ST_FLUSH);
  assign bus.out_valid = out_v;
  assign bus.out_row   = out_r;
  assign bus.out_col   = out_c;
  assign bus.border    = out_v && ((out_r == '0) || (out_r == RW'(IMG_H - 1)) ||
                                   (out_c == '0) || (out_c == CW'(IMG_W - 1)));
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Scoreboard bench for filter_window_ctrl on a 4x3 frame with 2-cycle latency.
module tb_filter_window_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  filter_window_ctrl_if #(.IMG_W(W), .IMG_H(H)) bus ();

  filter_window_ctrl #(.IMG_W(W), .IMG_H(H), .FILT_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int   at;
    int   row;
    int   col;
    logic brd;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   shifts   = 0;
  int   flushes  = 0;

  // Hand-derived border flags for raster index k = row*4 + col (only (1,1),(1,2) interior).
  logic [11:0] brd_bits = 12'b1111_1001_1111;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int out_pack();
    return {bus.in_ready, bus.win_shift, bus.flushing, bus.out_valid, bus.border,
            bus.busy, bus.done, bus.out_row, bus.out_col};
  endfunction

  exp_t mon_e;
  int   mon_d;

  // Monitor: pops the scoreboard whenever the DUT presents a tagged pixel or done.
  always @(negedge clk) begin
    if (bus.win_shift) shifts++;
    if (bus.flushing) flushes++;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got row=%0d col=%0d at cycle %0d, expected none",
                 bus.out_row, bus.out_col, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_cycle", cyc, mon_e.at);
        check("out_row", int'(bus.out_row), mon_e.row);
        check("out_col", int'(bus.out_col), mon_e.col);
        check("out_border", int'(bus.border), int'(mon_e.brd));
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        mon_d = done_q.pop_front();
        check("done_cycle", cyc, mon_d);
        check("done_idle_busy", int'(bus.busy), 0);
      end
    end
  end

  // One frame: optional in_valid gap, stray start pulse, or mid-frame reset.
  task automatic run_frame(input int stall_at, input int stall_len, input int stall_k,
                           input int start_again, input int rst_at);
    int base;
    int oc;
    @(posedge clk);
    #1;
    base         = cyc;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    shifts       = 0;
    flushes      = 0;
    for (int k = 0; k < W * H; k++) begin
      oc = 8 + k + ((stall_len > 0 && k >= stall_k) ? stall_len : 0);
      if (rst_at == 0 || oc <= rst_at)
        exp_q.push_back('{base + oc, k / W, k % W, brd_bits[k]});
    end
    if (rst_at == 0) done_q.push_back(base + 20 + stall_len);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      bus.start    = (c == start_again);
      bus.in_valid = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      rst          = (c == rst_at);
      if (rst_at != 0 && c == rst_at + 1) check("post_rst_outputs", out_pack(), 0);
    end
    check("missing_out", exp_q.size(), 0);
    check("missing_done", done_q.size(), 0);
    if (rst_at == 0) begin
      check("shift_count", shifts, 17);
      check("flush_count", flushes, 5);
    end
    exp_q.delete();
    done_q.delete();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_pack(), 0);
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_no_accept", int'({bus.in_ready, bus.win_shift, bus.busy}), 0);
    end
    run_frame(0, 0, 0, 0, 0);
    run_frame(7, 3, 2, 0, 0);
    run_frame(0, 0, 0, 7, 0);
    run_frame(0, 0, 0, 0, 10);
    run_frame(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
